// File: rtl/instr_mem_prog.sv
// instr_mem_prog
// ---------------------------------------------------------------------------
// Instruction memory for the RISC-V fetch stage with a byte-serial program
// loader, so a new program can be downloaded at run time (e.g. from a UART).
//
// Ports
//   clk          : single clock, all state updates on the rising edge
//   reset        : asynchronous, active-high
//   instr_rAddr  : byte address of the fetch
//   instr_req    : fetch request
//   instr_code   : fetched instruction, registered (one-cycle latency)
//   instr_valid  : instr_code holds the result of the previous-cycle request
//   instr_fault  : qualifies instr_valid; address misaligned or out of range
//   busy         : loader owns the memory, the core must stall fetch
//   prog_en      : load-mode request (level, a 0->1 edge starts a session)
//   prog_byte    : load data byte
//   prog_valid   : prog_byte is valid
//   prog_ready   : loader can accept a byte this cycle
//   prog_done    : one-cycle pulse when a load session ends
//   prog_count   : complete words written in the current/last session
// ---------------------------------------------------------------------------
module instr_mem_prog #(
    parameter int          DEPTH    = 64,
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                instr_rAddr,
    input  logic                       instr_req,
    output logic [31:0]                instr_code,
    output logic                       instr_valid,
    output logic                       instr_fault,
    output logic                       busy,
    input  logic                       prog_en,
    input  logic [7:0]                 prog_byte,
    input  logic                       prog_valid,
    output logic                       prog_ready,
    output logic                       prog_done,
    output logic [$clog2(DEPTH):0]     prog_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // The array holds (word ^ NOP_WORD). A zero-filled power-up image
    // therefore reads back as NOP_WORD in every location, without needing
    // an initialisation process or a clear on reset.
    logic [31:0]   mem_q [DEPTH];

    state_t        state_q;
    logic          prog_en_q;
    logic [1:0]    byte_cnt_q;
    logic [23:0]   asm_q;
    logic [CW-1:0] ptr_q;
    logic [CW-1:0] count_q;
    logic [31:0]   code_q;
    logic          valid_q;
    logic          fault_q;
    logic          busy_q;
    logic          ready_q;
    logic          done_q;

    logic          enter_d;
    logic          fetch_fault_d;
    logic [31:0]   fetch_word_d;
    logic          accept_d;
    logic          word_done_d;
    logic          full_d;
    logic [31:0]   wr_word_d;

    // A load session starts only on a registered 0->1 edge of prog_en, so a
    // level held high across DONE cannot immediately re-enter LOAD.
    assign enter_d       = prog_en && !prog_en_q;

    // Out of range means any address bit above the index field is set.
    assign fetch_fault_d = (instr_rAddr[1:0] != 2'b00) || (instr_rAddr[31:AW+2] != '0);
    assign fetch_word_d  = mem_q[instr_rAddr[AW+1:2]] ^ NOP_WORD;

    // The fourth accepted byte completes a little-endian word and is
    // written straight into memory together with the three buffered bytes.
    assign accept_d      = (state_q == LOAD) && prog_valid && ready_q;
    assign word_done_d   = accept_d && (byte_cnt_q == 2'd3);
    assign wr_word_d     = {prog_byte, asm_q};
    assign full_d        = word_done_d && (ptr_q == CW'(DEPTH - 1));

    // Memory write port; deliberately outside the reset domain so a reset
    // never disturbs a previously downloaded program.
    always_ff @(posedge clk) begin
        if (word_done_d) begin
            mem_q[ptr_q[AW-1:0]] <= wr_word_d ^ NOP_WORD;
        end
    end

    // Control FSM with all outputs registered. RUN serves fetches, LOAD
    // assembles bytes into words, DONE is a single-cycle handshake back to
    // RUN that raises prog_done while still holding busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            prog_en_q  <= 1'b0;
            byte_cnt_q <= 2'd0;
            asm_q      <= '0;
            ptr_q      <= '0;
            count_q    <= '0;
            code_q     <= NOP_WORD;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            prog_en_q <= prog_en;
            case (state_q)
                RUN: begin
                    done_q <= 1'b0;
                    if (enter_d) begin
                        // A fetch presented on the entry edge is dropped.
                        state_q    <= LOAD;
                        byte_cnt_q <= 2'd0;
                        ptr_q      <= '0;
                        count_q    <= '0;
                        busy_q     <= 1'b1;
                        ready_q    <= 1'b1;
                        valid_q    <= 1'b0;
                        fault_q    <= 1'b0;
                    end else begin
                        busy_q  <= 1'b0;
                        ready_q <= 1'b0;
                        if (instr_req) begin
                            valid_q <= 1'b1;
                            fault_q <= fetch_fault_d;
                            code_q  <= fetch_fault_d ? NOP_WORD : fetch_word_d;
                        end else begin
                            valid_q <= 1'b0;
                            fault_q <= 1'b0;
                        end
                    end
                end

                LOAD: begin
                    valid_q <= 1'b0;
                    fault_q <= 1'b0;
                    if (accept_d) begin
                        if (word_done_d) begin
                            byte_cnt_q <= 2'd0;
                            ptr_q      <= ptr_q + CW'(1);
                            count_q    <= count_q + CW'(1);
                        end else begin
                            case (byte_cnt_q)
                                2'd0:    asm_q[7:0]   <= prog_byte;
                                2'd1:    asm_q[15:8]  <= prog_byte;
                                default: asm_q[23:16] <= prog_byte;
                            endcase
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                        end
                    end
                    // A byte accepted on the exit edge is still taken above;
                    // any partial word is simply abandoned.
                    if (full_d || !prog_en) begin
                        state_q <= DONE;
                        ready_q <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end

                DONE: begin
                    state_q <= RUN;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                    fault_q <= 1'b0;
                end

                default: begin
                    state_q <= RUN;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                    fault_q <= 1'b0;
                end
            endcase
        end
    end

    assign instr_code  = code_q;
    assign instr_valid = valid_q;
    assign instr_fault = fault_q;
    assign busy        = busy_q;
    assign prog_ready  = ready_q;
    assign prog_done   = done_q;
    assign prog_count  = count_q;

endmodule
